// File: rtl/imul_add_seq.sv
// Sequential signed 16-bit multiply-add: out = sat16(a*b + c).
// Shift-add over 16 cycles on magnitudes, then sign fix-up, addend and saturation.
module imul_add_seq (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    input  logic signed [15:0] c,
    output logic               done,
    output logic signed [15:0] out,
    output logic               ovf
);
    localparam logic [4:0] CNT_IDLE = 5'd0;
    localparam logic [4:0] CNT_RUN0 = 5'd1;
    localparam logic [4:0] CNT_FIX  = 5'd17;
    localparam logic [4:0] CNT_HOLD = 5'd18;

    typedef enum logic [1:0] {IDLE, RUN, FIX, HOLD} phase_e;

    logic [4:0]         cnt, cnt_nxt;
    logic [31:0]        mcand, mcand_nxt;
    logic [15:0]        mplier, mplier_nxt;
    logic               neg, neg_nxt;
    logic signed [15:0] addend, addend_nxt;
    logic [31:0]        acc, acc_nxt;
    logic signed [15:0] out_nxt;
    logic               ovf_nxt;
    phase_e             phase;

    logic [16:0]        abs_a;
    logic [15:0]        abs_b;
    logic signed [32:0] prod;
    logic signed [33:0] sum;

    // 17 bits so that |-32768| survives the negation
    assign abs_a = a[15] ? 17'(-{a[15], a}) : {a[15], a};
    assign abs_b = b[15] ? 16'(-b) : 16'(b);
    assign prod  = neg ? -$signed({1'b0, acc}) : $signed({1'b0, acc});
    assign sum   = {prod[32], prod} + {{18{addend[15]}}, addend};

    assign done = (cnt == CNT_HOLD);

    always_comb begin
        if (cnt == CNT_IDLE)                       phase = IDLE;
        else if (cnt >= CNT_RUN0 && cnt < CNT_FIX) phase = RUN;
        else if (cnt == CNT_FIX)                   phase = FIX;
        else if (cnt == CNT_HOLD)                  phase = HOLD;
        else                                       phase = IDLE;
    end

    always_comb begin
        cnt_nxt    = cnt;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        neg_nxt    = neg;
        addend_nxt = addend;
        acc_nxt    = acc;
        out_nxt    = out;
        ovf_nxt    = ovf;
        case (phase)
            IDLE: begin
                // unreachable counts also fall back here and get cleared
                cnt_nxt = CNT_IDLE;
                if (en) begin
                    mcand_nxt  = {15'd0, abs_a};
                    mplier_nxt = abs_b;
                    neg_nxt    = a[15] ^ b[15];
                    addend_nxt = c;
                    acc_nxt    = 32'd0;
                    cnt_nxt    = CNT_RUN0;
                end
            end
            RUN: begin
                acc_nxt    = acc + (mplier[0] ? mcand : 32'd0);
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + 5'd1;
            end
            FIX: begin
                if (sum > 34'sd32767) begin
                    out_nxt = 16'sh7FFF;
                    ovf_nxt = 1'b1;
                end else if (sum < -34'sd32768) begin
                    out_nxt = 16'sh8000;
                    ovf_nxt = 1'b1;
                end else begin
                    out_nxt = sum[15:0];
                    ovf_nxt = 1'b0;
                end
                cnt_nxt = CNT_HOLD;
            end
            HOLD: begin
                if (!en) cnt_nxt = CNT_IDLE;
            end
            default: cnt_nxt = CNT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= CNT_IDLE;
            mcand  <= 32'd0;
            mplier <= 16'd0;
            neg    <= 1'b0;
            addend <= 16'sd0;
            acc    <= 32'd0;
            out    <= 16'sd0;
            ovf    <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            neg    <= neg_nxt;
            addend <= addend_nxt;
            acc    <= acc_nxt;
            out    <= out_nxt;
            ovf    <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_imul_add_seq.sv
// Directed bench for imul_add_seq: latency, handshake, saturation, aborts, back-to-back.
module tb_imul_add_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] a, b, c;
    logic        done;
    logic [15:0] out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    imul_add_seq dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
        .b   (b),
        .c   (c),
        .done(done),
        .out (out),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

    // Present operands with en=1 and count edges (capture edge = 1) until done; 0 on timeout.
    task automatic issue(input logic [15:0] ia, ib, ic, output int lat);
        @(negedge clk);
        a = ia; b = ib; c = ic; en = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic drop_en();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || out !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: done=%b out=%h ovf=%b, want 0 0000 0", done, out, ovf);
        end
        // rst and en together: rst wins, no operation starts
        @(negedge clk); en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); en = 1'b0; rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rst_en_idle: cycle %0d done=%b, want 0", i, done);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        issue(16'd7, -16'sd3, 16'd5, lat);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, want 18", lat);
        end
        checks++;
        if (out !== 16'hFFF0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: out=%h ovf=%b, want fff0 0", out, ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || out !== 16'hFFF0) begin
                errors++;
                $display("FAIL basic_hold: done=%b out=%h, want 1 fff0", done, out);
            end
        end
        drop_en();
        checks++;
        if (done !== 1'b0 || out !== 16'hFFF0) begin
            errors++;
            $display("FAIL basic_release: done=%b out=%h, want 0 fff0", done, out);
        end
    endtask

    task automatic test_divider_inverse();
        logic [15:0] va [2] = '{16'd14, -16'sd14};
        logic [15:0] vc [2] = '{16'd2, -16'sd2};
        logic [15:0] vx [2] = '{16'h0064, 16'hFF9C};
        int lat;
        for (int k = 0; k < 2; k++) begin
            issue(va[k], 16'd7, vc[k], lat);
            checks++;
            if (lat !== 18 || out !== vx[k] || ovf !== 1'b0) begin
                errors++;
                $display("FAIL divinv_%0d: lat=%0d out=%h ovf=%b, want 18 %h 0", k, lat, out, ovf, vx[k]);
            end
            drop_en();
        end
    endtask

    task automatic test_operand_stability();
        // prior result is -100 from the divider-inverse test
        @(negedge clk);
        a = 16'd3; b = 16'd4; c = 16'd0; en = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk); #1;
            checks++;
            if (i < 18) begin
                if (done !== 1'b0 || out !== 16'hFF9C) begin
                    errors++;
                    $display("FAIL stab_prior: edge %0d done=%b out=%h, want 0 ff9c", i, done, out);
                end
            end else if (done !== 1'b1 || out !== 16'd12 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL stab_result: done=%b out=%h ovf=%b, want 1 000c 0", done, out, ovf);
            end
            @(negedge clk);
            a = 16'(1000 + i * 37); b = 16'(-i * 11); c = 16'(i * 5);
        end
        drop_en();
    endtask

    task automatic test_saturation();
        logic [15:0] va [4] = '{16'h8000, 16'd300, 16'h8000, 16'h7FFF};
        logic [15:0] vb [4] = '{16'hFFFF, 16'd200, 16'd1,    16'd1};
        logic [15:0] vc [4] = '{16'd0,    16'd0,   16'hFFFF, 16'd1};
        logic [15:0] vx [4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF};
        int lat;
        for (int k = 0; k < 4; k++) begin
            issue(va[k], vb[k], vc[k], lat);
            checks++;
            if (lat !== 18 || out !== vx[k] || ovf !== 1'b1) begin
                errors++;
                $display("FAIL sat_%0d: lat=%0d out=%h ovf=%b, want 18 %h 1", k, lat, out, ovf, vx[k]);
            end
            drop_en();
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        @(negedge clk);
        a = 16'd100; b = 16'd100; c = 16'd0; en = 1'b1;
        repeat (8) @(posedge clk);   // capture edge + 7 RUN edges: now in RUN cycle 8
        @(negedge clk); rst = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || out !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst: done=%b out=%h ovf=%b, want 0 0000 0", done, out, ovf);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: cycle %0d done=%b, want 0", i, done);
            end
        end
        issue(-16'sd5, 16'd6, 16'd7, lat);
        checks++;
        if (lat !== 18 || out !== 16'hFFE9 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_recover: lat=%0d out=%h ovf=%b, want 18 ffe9 0", lat, out, ovf);
        end
        drop_en();
    endtask

    task automatic test_en_drop();
        int lat = 0;
        @(negedge clk);
        a = 16'd9; b = 16'd9; c = -16'sd1; en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 3) en = 1'b0;
            if (done) begin lat = i; break; end
        end
        checks++;
        if (lat !== 18 || out !== 16'h0050 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL endrop_result: lat=%0d out=%h ovf=%b, want 18 0050 0", lat, out, ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || out !== 16'h0050) begin
            errors++;
            $display("FAIL endrop_pulse: done=%b out=%h, want 0 0050", done, out);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(16'd1, 16'd1, 16'd0, lat);
        checks++;
        if (lat !== 18 || out !== 16'd1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d out=%h ovf=%b, want 18 0001 0", lat, out, ovf);
        end
        drop_en();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: done=%b, want 0", done);
        end
        issue(16'd2, 16'd3, 16'd4, lat);
        checks++;
        if (lat !== 18 || out !== 16'd10 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d out=%h ovf=%b, want 18 000a 0", lat, out, ovf);
        end
        drop_en();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: done=%b, want 0", done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divider_inverse();
        test_operand_stability();
        test_saturation();
        test_reset_abort();
        test_en_drop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imul_add_seq.md
# imul_add_seq

Sequential signed 16-bit multiply-add unit computing out = a*b + c with saturation to int16. It is the inverse companion of the sequential integer divider: feeding a quotient, divisor and remainder reconstructs the dividend. It uses the same en/done handshake as the other int16 arithmetic blocks, so it can sit beside them in the execution datapath. Its iterative shift-add core trades 18 cycles of latency for a single adder.

## Interface
- No parameters; all datapaths fixed at 16-bit signed two's complement.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  request; sampled in IDLE to start, held high by requester until it has consumed the result.
- done  out  1  result valid; high only in HOLD.
- a  in  16  signed multiplicand; captured on start.
- b  in  16  signed multiplier; captured on start.
- c  in  16  signed addend; captured on start.
- out  out  16  saturated signed result; registered.
- ovf  out  1  result saturated; registered with out.

## Operation
- State is encoded by a 5-bit counter cnt: IDLE (0), RUN (1..16), FIX (17), HOLD (18).
- IDLE, on en=1:
  - mcand (32-bit) <= |a| zero-extended; |-32768| = 32768 must be representable.
  - mplier (16-bit) <= |b|.
  - neg <= a[15]^b[15]; addend <= c; acc (32-bit) <= 0; cnt <= 1.
- RUN, each cycle:
  - acc <= acc + (mplier[0] ? mcand : 0).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - After 16 RUN cycles, acc = |a|*|b| (max 2^30; no overflow in 32 bits).
- FIX:
  - prod (33-bit signed) = neg ? -acc : acc.
  - sum (34-bit signed) = prod + sign-extended addend.
  - sum > 32767 -> out <= 16'h7FFF, ovf <= 1.
  - sum < -32768 -> out <= 16'h8000, ovf <= 1.
  - Otherwise out <= sum[15:0], ovf <= 0.
  - cnt <= 18.
- HOLD: done=1; en=0 -> cnt <= 0 (IDLE); en=1 -> remain in HOLD, with no restart and out stable.
- Operand changes after the start cycle are ignored.
- en dropping during RUN or FIX does not abort. The operation completes, enters HOLD, done is high for exactly one cycle, then the unit returns to IDLE.
- out/ovf hold the previous result in IDLE, RUN and HOLD; they change only at the FIX edge.

## Timing
- Reset values: cnt=0, done=0, out=16'h0000, ovf=0, acc=0.
- rst at any time, including mid-RUN or in HOLD, forces those values on the next edge. The in-flight operation is discarded and no done is produced.
- Latency: start edge E captures operands; done=1 is visible after edge E+18 (16 RUN + 1 FIX + 1 transition edge counted from capture).
- Minimum issue interval: done high at E+18; with en low at E+18 the unit is in IDLE after E+19, so the next start is sampled at edge E+20.
- done is combinational from cnt (cnt==18) with no other logic.
- Simultaneous rst and en: rst wins; the unit stays in IDLE.

## Test plan
- a=7, b=-3, c=5 with en held -> done after 18 edges, out=16'hFFF0 (-16), ovf=0; done stays high while en=1; en low -> done=0 next cycle.
- Divider inverse: a=14, b=7, c=2 -> out=100 (16'h0064); a=-14, b=7, c=-2 -> out=-100 (16'hFF9C); ovf=0 for both.
- Saturation cases:
  - a=-32768, b=-1, c=0 -> out=16'h7FFF, ovf=1.
  - a=300, b=200, c=0 -> out=16'h7FFF, ovf=1.
  - a=-32768, b=1, c=-1 -> out=16'h8000, ovf=1.
  - a=32767, b=1, c=1 -> out=16'h7FFF, ovf=1.
- Operand stability: start with a=3, b=4, c=0, then change a, b, c every cycle during RUN -> out=12, ovf=0; out keeps the prior value until the FIX edge.
- Abort behaviour:
  - Assert rst at RUN cycle 8 -> next cycle cnt=0, out=0, done=0; a new en then produces a correct result.
  - Deassert en at RUN cycle 3 -> done pulses exactly one cycle at E+18.
- Back-to-back: issue 1*1+0, then 2*3+4 at the earliest legal edge (E+20) -> results 1 and 10, each with a clean done.
